// File: rtl/alram_rd_arb.sv
// alram_rd_arb: two-client read arbiter and write-port sequencer for a dual-port
// RAM with pipelined read (registered address plus registered data).
// Requesters A and B share the single read port with round-robin grant. Each issued
// read is tagged with its owner, and the data is returned to that owner after the
// fixed RAM latency. The write port is registered alongside the read address.
// A read that collides with a same-cycle write to the same address is stalled.
// Optional macro ALRAM_RD_ARB_FIXPRIO_EN: A always beats B on a tie, and there is
// no last-grant state.

module alram_rd_arb #(
    parameter int WID  = 256,
    parameter int AWID = 5,
    parameter int RLAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rqa,
    input  logic [AWID-1:0] raa,
    output logic            gnta,
    input  logic            rqb,
    input  logic [AWID-1:0] rab,
    output logic            gntb,
    output logic [WID-1:0]  rdo,
    output logic            rdva,
    output logic            rdvb,
    input  logic            wreq,
    input  logic [AWID-1:0] wadr,
    input  logic [WID-1:0]  wdat,
    output logic [AWID-1:0] ram_ra,
    input  logic [WID-1:0]  ram_rdo,
    output logic [AWID-1:0] ram_wa,
    output logic [WID-1:0]  ram_wdi,
    output logic            ram_we
);

    // The tail stage lines up with ram_rdo, one cycle before the return is registered
    localparam int NTAG = RLAT + 1;

    logic            col_a, col_b, elig_a, elig_b;
    logic [AWID-1:0] ram_ra_q, ram_ra_d;
    logic [NTAG-1:0] tag_vld_q, tag_vld_d;
    logic [NTAG-1:0] tag_own_q, tag_own_d;   // 1 = owned by B
    logic [WID-1:0]  rdo_q, rdo_d;
    logic            rdva_q, rdva_d, rdvb_q, rdvb_d;
    logic            ram_we_q, ram_we_d;
    logic [AWID-1:0] ram_wa_q, ram_wa_d;
    logic [WID-1:0]  ram_wdi_q, ram_wdi_d;
`ifndef ALRAM_RD_ARB_FIXPRIO_EN
    logic            lst_q, lst_d;           // 1 = B was granted last
`endif

    // Eligibility after the write-collision stall, then a single grant
    always_comb begin
        col_a  = wreq && (raa == wadr);
        col_b  = wreq && (rab == wadr);
        elig_a = rqa && !col_a;
        elig_b = rqb && !col_b;
        gnta   = 1'b0;
        gntb   = 1'b0;
        if (!rst) begin
`ifdef ALRAM_RD_ARB_FIXPRIO_EN
            gnta = elig_a;
`else
            gnta = elig_a && (!elig_b || lst_q);
`endif
            gntb = elig_b && !gnta;
        end
    end

    // Next state: read issue, tag shift, data return and write-port registering
    always_comb begin
        ram_ra_d  = ram_ra_q;
        if (gnta) begin
            ram_ra_d = raa;
        end else if (gntb) begin
            ram_ra_d = rab;
        end
        tag_vld_d = {tag_vld_q[NTAG-2:0], gnta | gntb};
        tag_own_d = {tag_own_q[NTAG-2:0], gntb};
        rdo_d     = tag_vld_q[NTAG-1] ? ram_rdo : rdo_q;
        rdva_d    = tag_vld_q[NTAG-1] && !tag_own_q[NTAG-1];
        rdvb_d    = tag_vld_q[NTAG-1] &&  tag_own_q[NTAG-1];
        ram_we_d  = wreq;
        ram_wa_d  = wreq ? wadr : ram_wa_q;
        ram_wdi_d = wreq ? wdat : ram_wdi_q;
`ifndef ALRAM_RD_ARB_FIXPRIO_EN
        lst_d     = gnta ? 1'b0 : (gntb ? 1'b1 : lst_q);
`endif
    end

    // State registers; reset drops every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ra_q  <= '0;
            tag_vld_q <= '0;
            tag_own_q <= '0;
            rdo_q     <= '0;
            rdva_q    <= 1'b0;
            rdvb_q    <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_wa_q  <= '0;
            ram_wdi_q <= '0;
`ifndef ALRAM_RD_ARB_FIXPRIO_EN
            lst_q     <= 1'b1;
`endif
        end else begin
            ram_ra_q  <= ram_ra_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
            rdo_q     <= rdo_d;
            rdva_q    <= rdva_d;
            rdvb_q    <= rdvb_d;
            ram_we_q  <= ram_we_d;
            ram_wa_q  <= ram_wa_d;
            ram_wdi_q <= ram_wdi_d;
`ifndef ALRAM_RD_ARB_FIXPRIO_EN
            lst_q     <= lst_d;
`endif
        end
    end

    assign ram_ra  = ram_ra_q;
    assign rdo     = rdo_q;
    assign rdva    = rdva_q;
    assign rdvb    = rdvb_q;
    assign ram_we  = ram_we_q;
    assign ram_wa  = ram_wa_q;
    assign ram_wdi = ram_wdi_q;

endmodule
